logic_gate_unit: RTL and testbench

Registered bank of the seven basic two-input logic functions (NOT, AND, OR, NAND, NOR, XOR, XNOR), computed bitwise over a parameterised operand width. It also provides a selectable single result with a valid flag. It is the reference combinational-logic primitive used by datapath blocks and by tutorial and waveform benches. All outputs are registered on one clock with a synchronous, active-low reset.

---
 rtl/logic_gate_pkg.sv | 20 ++
 rtl/logic_gate_core.sv | 62 ++++++
 rtl/logic_gate_unit.sv | 112 +++++++++++
 tb/tb_logic_gate_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// -----------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for the logic gate unit: the 3-bit op_sel encoding that
// picks which bitwise function is driven on the single selectable result.
// -----------------------------------------------------------------------------
package logic_gate_pkg;

    localparam int OP_SEL_W = 3;

    localparam logic [OP_SEL_W-1:0] OP_NOT  = 3'd0;
    localparam logic [OP_SEL_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_SEL_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_SEL_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_SEL_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_SEL_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_SEL_W-1:0] OP_XNOR = 3'd6;
    // Reserved code: the selected result is forced to zero.
    localparam logic [OP_SEL_W-1:0] OP_RSVD = 3'd7;

endpackage : logic_gate_pkg

// File: rtl/logic_gate_core.sv
// -----------------------------------------------------------------------------
// logic_gate_core
// Purely combinational bank of the seven bitwise two-input functions plus the
// op_sel multiplexer for the single selectable result.
//
// Ports:
//   i_a, i_b     [WIDTH]  operands
//   i_op_sel     [3]      function select (see logic_gate_pkg)
//   o_not..o_xnor[WIDTH]  bitwise ~A, A&B, A|B, ~(A&B), ~(A|B), A^B, ~(A^B)
//   o_result     [WIDTH]  function chosen by i_op_sel, zero for reserved code
// -----------------------------------------------------------------------------
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  logic [OP_SEL_W-1:0] i_op_sel,
    output logic [WIDTH-1:0]    o_not,
    output logic [WIDTH-1:0]    o_and,
    output logic [WIDTH-1:0]    o_or,
    output logic [WIDTH-1:0]    o_nand,
    output logic [WIDTH-1:0]    o_nor,
    output logic [WIDTH-1:0]    o_xor,
    output logic [WIDTH-1:0]    o_xnor,
    output logic [WIDTH-1:0]    o_result
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;

    assign w_and  = i_a & i_b;
    assign w_or   = i_a | i_b;
    assign w_xor  = i_a ^ i_b;

    assign o_not  = ~i_a;
    assign o_and  = w_and;
    assign o_or   = w_or;
    assign o_nand = ~w_and;
    assign o_nor  = ~w_or;
    assign o_xor  = w_xor;
    assign o_xnor = ~w_xor;

    always_comb begin
        // NOTE: default assigned before the case so no path leaves o_result
        // unassigned; a missing default here would infer a latch.
        o_result = '0;
        case (i_op_sel)
            OP_NOT:  o_result = ~i_a;
            OP_AND:  o_result = w_and;
            OP_OR:   o_result = w_or;
            OP_NAND: o_result = ~w_and;
            OP_NOR:  o_result = ~w_or;
            OP_XOR:  o_result = w_xor;
            OP_XNOR: o_result = ~w_xor;
            default: o_result = '0;
        endcase
    end

endmodule : logic_gate_core

// File: rtl/logic_gate_unit.sv
// -----------------------------------------------------------------------------
// logic_gate_unit
// Registered bank of the seven bitwise logic functions with a selectable single
// result and a valid flag. One cycle latency, one operand pair per cycle, no
// backpressure. Synchronous active-low reset clears every output to 0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   A, B      [WIDTH] operands
//   in_valid          A/B/op_sel valid this cycle
//   op_sel    [3]     function driven on result
//   not_out..xnor_out registered bitwise functions (free-running)
//   result    [WIDTH] registered selected function
//   out_valid         registered copy of in_valid
// -----------------------------------------------------------------------------
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic                in_valid,
    input  logic [OP_SEL_W-1:0] op_sel,
    output logic [WIDTH-1:0]    not_out,
    output logic [WIDTH-1:0]    and_out,
    output logic [WIDTH-1:0]    or_out,
    output logic [WIDTH-1:0]    nand_out,
    output logic [WIDTH-1:0]    nor_out,
    output logic [WIDTH-1:0]    xor_out,
    output logic [WIDTH-1:0]    xnor_out,
    output logic [WIDTH-1:0]    result,
    output logic                out_valid
);

    logic [WIDTH-1:0] w_not;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_xnor;
    logic [WIDTH-1:0] w_result;

    logic [WIDTH-1:0] r_not;
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_nand;
    logic [WIDTH-1:0] r_nor;
    logic [WIDTH-1:0] r_xor;
    logic [WIDTH-1:0] r_xnor;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    logic_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (A),
        .i_b      (B),
        .i_op_sel (op_sel),
        .o_not    (w_not),
        .o_and    (w_and),
        .o_or     (w_or),
        .o_nand   (w_nand),
        .o_nor    (w_nor),
        .o_xor    (w_xor),
        .o_xnor   (w_xnor),
        .o_result (w_result)
    );

    // Reset forces true zeros, not the function of zero inputs, so the
    // inverting outputs read 0 while rst_n is low.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values; blocking here would create ordering races.
        if (!rst_n) begin
            r_not    <= '0;
            r_and    <= '0;
            r_or     <= '0;
            r_nand   <= '0;
            r_nor    <= '0;
            r_xor    <= '0;
            r_xnor   <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            // Gate outputs update every cycle; in_valid only qualifies result.
            r_not    <= w_not;
            r_and    <= w_and;
            r_or     <= w_or;
            r_nand   <= w_nand;
            r_nor    <= w_nor;
            r_xor    <= w_xor;
            r_xnor   <= w_xnor;
            r_result <= w_result;
            r_valid  <= in_valid;
        end
    end

    assign not_out   = r_not;
    assign and_out   = r_and;
    assign or_out    = r_or;
    assign nand_out  = r_nand;
    assign nor_out   = r_nor;
    assign xor_out   = r_xor;
    assign xnor_out  = r_xnor;
    assign result    = r_result;
    assign out_valid = r_valid;

endmodule : logic_gate_unit

// File: tb/tb_logic_gate_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_gate_unit
// Drives a WIDTH=4 and a WIDTH=1 instance from the same stimulus. Expected
// responses come from a truth-table reference model and are queued by the
// driver; a monitor pops one entry per clock and compares all outputs.
// -----------------------------------------------------------------------------
module tb_logic_gate_unit;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] gate [7];
        logic [W-1:0] res;
        logic         vld;
        logic         gate1 [7];
        logic         res1;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         in_valid;
    logic [2:0]   op_sel;

    logic [W-1:0] not_out, and_out, or_out, nand_out, nor_out, xor_out, xnor_out, result;
    logic         out_valid;
    logic         not1, and1, or1, nand1, nor1, xor1, xnor1, result1, out_valid1;

    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;

    always #5 clk = ~clk;

    logic_gate_unit #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .op_sel(op_sel),
        .not_out(not_out), .and_out(and_out), .or_out(or_out), .nand_out(nand_out),
        .nor_out(nor_out), .xor_out(xor_out), .xnor_out(xnor_out),
        .result(result), .out_valid(out_valid)
    );

    logic_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .A(A[0]), .B(B[0]), .in_valid(in_valid), .op_sel(op_sel),
        .not_out(not1), .and_out(and1), .or_out(or1), .nand_out(nand1),
        .nor_out(nor1), .xor_out(xor1), .xnor_out(xnor1),
        .result(result1), .out_valid(out_valid1)
    );

    // Truth table of function 'op': bit {a,b} holds the output for that pair.
    function automatic logic [3:0] truth(input int op);
        case (op)
            0:       return 4'b0011;  // NOT a
            1:       return 4'b1000;  // AND
            2:       return 4'b1110;  // OR
            3:       return 4'b0111;  // NAND
            4:       return 4'b0001;  // NOR
            5:       return 4'b0110;  // XOR
            6:       return 4'b1001;  // XNOR
            default: return 4'b0000;  // reserved
        endcase
    endfunction

    function automatic logic [W-1:0] apply(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0]   tt;
        logic [W-1:0] r;
        tt = truth(op);
        for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cycle, name, got, exp);
        end
    endtask

    // Apply one input set before the next rising edge and queue its response.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic v, input logic rn);
        exp_t e;
        @(negedge clk);
        A = a; B = b; op_sel = op; in_valid = v; rst_n = rn;
        for (int k = 0; k < 7; k++) begin
            e.gate[k]  = rn ? apply(k, a, b) : '0;
            e.gate1[k] = rn ? apply(k, a, b) & 1'b1 : 1'b0;
        end
        e.res  = rn ? apply(int'(op), a, b) : '0;
        e.res1 = rn ? (apply(int'(op), a, b) & 1'b1) : 1'b0;
        e.vld  = rn & v;
        exp_q.push_back(e);
    endtask

    // Monitor: sample #1 after each rising edge, compare against queued entry.
    initial begin : monitor
        logic [W-1:0] g [7];
        logic         g1 [7];
        string        names [7];
        exp_t         e;
        names = '{"not", "and", "or", "nand", "nor", "xor", "xnor"};
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g  = '{not_out, and_out, or_out, nand_out, nor_out, xor_out, xnor_out};
                g1 = '{not1, and1, or1, nand1, nor1, xor1, xnor1};
                for (int k = 0; k < 7; k++) begin
                    check({names[k], "_out"}, 32'(g[k]), 32'(e.gate[k]));
                    check({names[k], "_out_w1"}, 32'(g1[k]), 32'(e.gate1[k]));
                end
                check("result", 32'(result), 32'(e.res));
                check("result_w1", 32'(result1), 32'(e.res1));
                check("out_valid", 32'(out_valid), 32'(e.vld));
                check("out_valid_w1", 32'(out_valid1), 32'(e.vld));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0; A = '0; B = '0; op_sel = '0; in_valid = 1'b0;

        // Reset held with zero operands: inverting outputs must read 0.
        repeat (3) drive(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        // First edge after release: not/nand/nor/xnor become 1.
        drive(4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1);

        // Exhaustive single-bit pairs 00, 01, 10, 11.
        for (int p = 0; p < 4; p++)
            drive(W'(p >> 1), W'(p & 1), 3'(p), 1'b1, 1'b1);

        // op_sel sweep 0..7 on A=1100, B=1010, including reserved code.
        for (int op = 0; op < 8; op++)
            drive(4'b1100, 4'b1010, 3'(op), 1'b1, 1'b1);

        // in_valid toggling 1,0,1 while operands keep changing.
        drive(4'b0101, 4'b0011, 3'd5, 1'b1, 1'b1);
        drive(4'b1111, 4'b0000, 3'd1, 1'b0, 1'b1);
        drive(4'b1001, 4'b0110, 3'd6, 1'b1, 1'b1);

        // Back-to-back valid inputs with a one-cycle mid-stream reset pulse.
        for (int i = 0; i < 6; i++)
            drive(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'b1, (i == 3) ? 1'b0 : 1'b1);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 300; i++)
            drive(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom), ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1);

        // Let the last queued response be consumed.
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_logic_gate_unit
